// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer and the control decoder:
// the sequencer state encoding, the opcode/function constants both blocks
// agree on, and a helper that classifies multiply instructions.
package instr_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_MULWAIT = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE        = 6'b000000;
   localparam logic [5:0] OP_ADDI         = 6'b001000;
   localparam logic [5:0] OP_MUL2         = 6'b011100;
   localparam logic [5:0] FUNCT_MULT      = 6'b011000;
   localparam logic [5:0] FUNCT_MUL       = 6'b000010;
   localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

   // Both multiply encodings need the stretched execute phase.
   function automatic logic is_mul(input logic [5:0] op, input logic [5:0] funct);
      return ((op == OP_RTYPE) && (funct == FUNCT_MULT)) ||
             ((op == OP_MUL2)  && (funct == FUNCT_MUL));
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if
// Instruction-memory fetch handshake.
//   IMEM_REQ : fetch request (sequencer -> memory)
//   PC       : fetch address (sequencer -> memory)
//   INSTR    : read data     (memory -> sequencer)
//   IMEM_ACK : data valid    (memory -> sequencer)
// master = sequencer side, slave = memory side.
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            IMEM_REQ;
   logic [PC_W-1:0] PC;
   logic [31:0]     INSTR;
   logic            IMEM_ACK;

   modport master (output IMEM_REQ, output PC, input INSTR, input IMEM_ACK);
   modport slave  (input IMEM_REQ, input PC, output INSTR, output IMEM_ACK);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle phase sequencer: FETCH -> DECODE -> EXEC [-> MULWAIT] -> WB,
// looping until the halt opcode is decoded. Drives the decoder enable HAB
// during execute and a one-cycle write-back strobe before the PC advances.
// Ports:
//   CLK, RESET_N : clock, synchronous active-low reset
//   START        : leave IDLE
//   imem         : fetch handshake (IMEM_REQ, PC, INSTR, IMEM_ACK)
//   OP_CODE      : IR[31:26] to decoder
//   FUNCT        : IR[5:0] to decoder
//   HAB          : decoder enable (EXEC and MULWAIT)
//   WB_EN        : write-back strobe (WB)
//   BUSY, DONE   : activity / halted status
//   RETIRED      : saturating retired-instruction count
// All outputs come from registers or decoded registered state.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int         PC_W    = 8,
   parameter int         MUL_LAT = 4,
   parameter logic [5:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                START,
   instr_sequencer_if.master   imem,
   output logic [5:0]          OP_CODE,
   output logic [5:0]          FUNCT,
   output logic                HAB,
   output logic                WB_EN,
   output logic                BUSY,
   output logic                DONE,
   output logic [15:0]         RETIRED
);

   // Counter only needs to hold MUL_LAT-1.
   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc;
   logic [5:0]        ir_op;
   logic [5:0]        ir_funct;
   logic [CNT_W-1:0]  mul_cnt;
   logic [15:0]       retired;

   // Only the opcode and function fields are consumed here; the register and
   // immediate fields belong to the datapath, which reads memory directly.
   logic unused_instr_bits;
   assign unused_instr_bits = ^imem.INSTR[25:6];

   // State register
   always_ff @(posedge CLK) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (START) state_nxt = S_FETCH;
         S_FETCH:   if (imem.IMEM_ACK) state_nxt = S_DECODE;
         S_DECODE:  state_nxt = (ir_op == HALT_OP) ? S_HALT : S_EXEC;
         S_EXEC:    state_nxt = is_mul(ir_op, ir_funct) ? S_MULWAIT : S_WB;
         S_MULWAIT: if (mul_cnt == '0) state_nxt = S_WB;
         S_WB:      state_nxt = S_FETCH;
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers: PC, IR fields, multiply counter, retire counter
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         pc       <= '0;
         ir_op    <= '0;
         ir_funct <= '0;
         mul_cnt  <= '0;
         retired  <= '0;
      end else begin
         if (state == S_FETCH && imem.IMEM_ACK) begin
            ir_op    <= imem.INSTR[31:26];
            ir_funct <= imem.INSTR[5:0];
         end
         if (state == S_EXEC && is_mul(ir_op, ir_funct))
            mul_cnt <= CNT_W'(MUL_LAT - 1);
         else if (state == S_MULWAIT && mul_cnt != '0)
            mul_cnt <= mul_cnt - 1'b1;
         if (state == S_WB) begin
            pc <= pc + 1'b1;   // wraps naturally at 2^PC_W
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
         end
      end
   end

   assign imem.IMEM_REQ = (state == S_FETCH);
   assign imem.PC       = pc;
   assign OP_CODE       = ir_op;
   assign FUNCT         = ir_funct;
   assign HAB           = (state == S_EXEC) || (state == S_MULWAIT);
   assign WB_EN         = (state == S_WB);
   assign BUSY          = (state != S_IDLE) && (state != S_HALT);
   assign DONE          = (state == S_HALT);
   assign RETIRED       = retired;

endmodule
